// File: rtl/axi_rd_burst_master_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_rd_burst_master_pkg                                                    |
// | Shared AXI encodings, FSM state codes and helpers for the read master.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package axi_rd_burst_master_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_rd_burst_master_len_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_rd_len_fifo                                                            |
// | Small FIFO of per-burst beat counts (arlen) for bursts in flight.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module axi_rd_len_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= next_ptr(rd_ptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/axi_rd_burst_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_rd_burst_master                                                        |
// | AXI4 read master: splits a user request into row-safe INCR bursts.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module axi_rd_burst_master
    import axi_rd_burst_master_pkg::*;
#(
    parameter int         ADDR_WIDTH = 27,
    parameter int         DATA_WIDTH = 16,
    parameter int         COL_BITS   = 10,
    parameter int         MAX_BURST  = 16,
    parameter int         MAX_OUTSTD = 2,
    parameter int         LEN_WIDTH  = 16,
    parameter logic [3:0] AXI_ID     = 4'hF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_end_i,
    input  logic                  rd_trig_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [LEN_WIDTH-1:0]  rd_len_i,
    output logic                  rd_ready_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_data_en_o,
    input  logic                  rd_data_ready_i,
    output logic                  rd_done_o,
    output logic                  rd_err_o,
    output logic [3:0]            axi_arid_o,
    output logic [ADDR_WIDTH-1:0] axi_araddr_o,
    output logic [7:0]            axi_arlen_o,
    output logic [2:0]            axi_arsize_o,
    output logic [1:0]            axi_arburst_o,
    output logic                  axi_arvalid_o,
    input  logic                  axi_arready_i,
    input  logic [DATA_WIDTH-1:0] axi_rdata_i,
    input  logic [1:0]            axi_rresp_i,
    input  logic                  axi_rlast_i,
    input  logic                  axi_rvalid_i,
    output logic                  axi_rready_o
);

    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int SZ        = clog2_f(BYTES);
    localparam int OW        = $clog2(MAX_OUTSTD + 1);
    localparam int ROW_BEATS = 1 << COL_BITS;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic [LEN_WIDTH-1:0]  ar_remain_q, ar_remain_d;
    logic [LEN_WIDTH-1:0]  rd_remain_q, rd_remain_d;
    logic [OW-1:0]         outstd_q, outstd_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic                  err_q, err_d;
    logic                  arvalid_q, arvalid_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [7:0]            arlen_q, arlen_d;

    logic [31:0] w_row_left;
    logic [31:0] w_burst;
    logic        w_ar_hs;
    logic        w_beat;
    logic        w_last;
    logic        w_pop;
    logic        w_accept;
    logic        w_rready;
    logic [7:0]  w_head_len;

    // Beats left before the DDR2 row boundary caps the burst alongside MAX_BURST.
    always_comb begin
        w_row_left = 32'(ROW_BEATS) - 32'(ar_addr_q[SZ +: COL_BITS]);
        w_burst    = 32'(ar_remain_q);
        if (w_burst > 32'(MAX_BURST)) w_burst = 32'(MAX_BURST);
        if (w_burst > w_row_left)     w_burst = w_row_left;
    end

    assign w_ar_hs  = arvalid_q & axi_arready_i;
    assign w_beat   = axi_rvalid_i & w_rready;
    assign w_last   = (beat_cnt_q == w_head_len);
    assign w_pop    = w_beat & w_last;
    assign w_accept = rd_ready_o & rd_trig_i;

    axi_rd_len_fifo #(
        .DEPTH (MAX_OUTSTD),
        .WIDTH (8)
    ) u_len_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (w_ar_hs),
        .data_i (arlen_q),
        .pop_i  (w_pop),
        .data_o (w_head_len)
    );

    always_comb begin
        ar_addr_d   = ar_addr_q;
        ar_remain_d = ar_remain_q;
        rd_remain_d = rd_remain_q;
        outstd_d    = outstd_q;
        beat_cnt_d  = beat_cnt_q;
        err_d       = err_q;
        arvalid_d   = arvalid_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;

        if (w_accept) begin
            ar_addr_d   = rd_addr_i & ~ADDR_WIDTH'(BYTES - 1);
            ar_remain_d = rd_len_i;
            rd_remain_d = rd_len_i;
            beat_cnt_d  = '0;
            err_d       = 1'b0;
        end

        if (state_q == ST_ISSUE) begin
            if (w_ar_hs) begin
                arvalid_d   = 1'b0;
                ar_addr_d   = ar_addr_q + ADDR_WIDTH'(w_burst << SZ);
                ar_remain_d = ar_remain_q - LEN_WIDTH'(w_burst);
            end else if (!arvalid_q && ar_remain_q != '0 && outstd_q < OW'(MAX_OUTSTD)) begin
                arvalid_d = 1'b1;
                araddr_d  = ar_addr_q;
                arlen_d   = 8'(w_burst - 32'd1);
            end
        end

        case ({w_ar_hs, w_pop})
            2'b10:   outstd_d = outstd_q + OW'(1);
            2'b01:   outstd_d = outstd_q - OW'(1);
            default: outstd_d = outstd_q;
        endcase

        if (w_beat) begin
            rd_remain_d = rd_remain_q - LEN_WIDTH'(1);
            beat_cnt_d  = w_last ? '0 : beat_cnt_q + 8'd1;
            if ((axi_rlast_i != w_last) || (axi_rresp_i == AXI_RESP_SLVERR) ||
                (axi_rresp_i == AXI_RESP_DECERR)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (w_accept) state_d = (rd_len_i != '0) ? ST_ISSUE : ST_DONE;
            ST_ISSUE: if (w_ar_hs && ar_remain_d == '0) state_d = ST_DRAIN;
            ST_DRAIN: if (rd_remain_d == '0 && outstd_d == '0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_ready_o = 1'b0;
        rd_done_o  = 1'b0;
        rd_err_o   = 1'b0;
        w_rready   = 1'b0;
        case (state_q)
            ST_IDLE:            rd_ready_o = init_end_i;
            ST_ISSUE, ST_DRAIN: w_rready   = rd_data_ready_i & (outstd_q != '0);
            ST_DONE: begin
                rd_done_o = 1'b1;
                rd_err_o  = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_addr_q   <= '0;
            ar_remain_q <= '0;
            rd_remain_q <= '0;
            outstd_q    <= '0;
            beat_cnt_q  <= '0;
            err_q       <= 1'b0;
            arvalid_q   <= 1'b0;
            araddr_q    <= '0;
            arlen_q     <= '0;
        end else begin
            ar_addr_q   <= ar_addr_d;
            ar_remain_q <= ar_remain_d;
            rd_remain_q <= rd_remain_d;
            outstd_q    <= outstd_d;
            beat_cnt_q  <= beat_cnt_d;
            err_q       <= err_d;
            arvalid_q   <= arvalid_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
        end
    end

    assign axi_arid_o    = AXI_ID;
    assign axi_araddr_o  = araddr_q;
    assign axi_arlen_o   = arlen_q;
    assign axi_arsize_o  = 3'(SZ);
    assign axi_arburst_o = AXI_BURST_INCR;
    assign axi_arvalid_o = arvalid_q;
    assign axi_rready_o  = w_rready;
    assign rd_data_o     = axi_rdata_i;
    assign rd_data_en_o  = w_beat;

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_burst_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_axi_rd_burst_master                                                     |
// | Scoreboard bench with a small AXI read slave model.                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_axi_rd_burst_master;

    localparam int MAXB = 16;
    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_end;
    logic        rd_trig;
    logic [26:0] rd_addr;
    logic [15:0] rd_len;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic        rd_data_en;
    logic        rd_data_ready;
    logic        rd_done;
    logic        rd_err;
    logic [3:0]  arid;
    logic [26:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [15:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    axi_rd_burst_master dut (
        .clk             (clk),
        .rst             (rst),
        .init_end_i      (init_end),
        .rd_trig_i       (rd_trig),
        .rd_addr_i       (rd_addr),
        .rd_len_i        (rd_len),
        .rd_ready_o      (rd_ready),
        .rd_data_o       (rd_data),
        .rd_data_en_o    (rd_data_en),
        .rd_data_ready_i (rd_data_ready),
        .rd_done_o       (rd_done),
        .rd_err_o        (rd_err),
        .axi_arid_o      (arid),
        .axi_araddr_o    (araddr),
        .axi_arlen_o     (arlen),
        .axi_arsize_o    (arsize),
        .axi_arburst_o   (arburst),
        .axi_arvalid_o   (arvalid),
        .axi_arready_i   (arready),
        .axi_rdata_i     (rdata),
        .axi_rresp_i     (rresp),
        .axi_rlast_i     (rlast),
        .axi_rvalid_i    (rvalid),
        .axi_rready_o    (rready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [26:0] exp_ar_addr[$];
    logic [7:0]  exp_ar_len[$];
    logic [15:0] exp_data[$];
    logic [26:0] sb_addr[$];
    logic [7:0]  sb_len[$];
    int          sb_avail[$];

    int slv_idx = 0, req_beat = 0, err_beat = -1, pending = 0, r_delay = 0;
    int cyc = 0, accept_cyc = 0, last_beat_cyc = 0, exp_len = 0;
    bit done_flag = 0, exp_err = 0, toggle_mode = 0, ar_rand = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] beat_data(input logic [26:0] a);
        return a[16:1] ^ 16'h3C5A;
    endfunction

    // Independent model of the burst split: beat cap and 1024-beat row boundary.
    task automatic model_req(input logic [26:0] a, input int len);
        logic [26:0] cur;
        int rem, col, b;
        cur = a & ~27'd1;
        rem = len;
        for (int i = 0; i < len; i++) exp_data.push_back(beat_data(cur + 27'(2 * i)));
        while (rem > 0) begin
            col = int'((cur >> 1) & 27'd1023);
            b = rem;
            if (b > MAXB) b = MAXB;
            if (b > 1024 - col) b = 1024 - col;
            exp_ar_addr.push_back(cur);
            exp_ar_len.push_back(8'(b - 1));
            cur = cur + 27'(2 * b);
            rem = rem - b;
        end
    endtask

    task automatic start_req(input logic [26:0] a, input int len);
        model_req(a, len);
        req_beat  = 0;
        exp_len   = len;
        done_flag = 0;
        @(posedge clk); #1;
        rd_trig = 1'b1;
        rd_addr = a;
        rd_len  = 16'(len);
        @(posedge clk); #1;
        rd_trig = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done_flag; i++) @(posedge clk);
        check_eq("done_seen", 64'(done_flag), 64'd1);
    endtask

    // Slave driver: inputs change 1 time unit after the rising edge.
    initial begin
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
        rd_data_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
            end else begin
                arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                rd_data_ready = toggle_mode ? ~rd_data_ready : 1'b1;
                if (sb_addr.size() > 0 && cyc >= sb_avail[0]) begin
                    rvalid = 1'b1;
                    rdata  = beat_data(sb_addr[0] + 27'(2 * slv_idx));
                    rlast  = (slv_idx == int'(sb_len[0]));
                    rresp  = (req_beat == err_beat) ? 2'b10 : 2'b00;
                end else begin
                    rvalid = 1'b0;
                    rlast  = 1'b0;
                    rresp  = 2'b00;
                end
            end
        end
    end

    // Monitor: values are stable at the falling edge and show what the next rising edge takes.
    initial begin
        int ref_cyc;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (rd_ready && rd_trig) accept_cyc = cyc;
                if (rvalid && rready) begin
                    check_eq("rd_data_en", 64'(rd_data_en), 64'd1);
                    last_beat_cyc = cyc;
                    if (exp_data.size() == 0) check_eq("extra_beat", 64'd1, 64'd0);
                    else check_eq("rd_data", 64'(rd_data), 64'(exp_data.pop_front()));
                    req_beat++;
                    if (slv_idx == int'(sb_len[0])) begin
                        void'(sb_addr.pop_front());
                        void'(sb_len.pop_front());
                        void'(sb_avail.pop_front());
                        slv_idx = 0;
                        pending--;
                    end else begin
                        slv_idx++;
                    end
                end else if (rd_data_en) begin
                    check_eq("spurious_en", 64'(rd_data_en), 64'd0);
                end
                if (arvalid && arready) begin
                    if (exp_ar_addr.size() == 0) begin
                        check_eq("extra_ar", 64'd1, 64'd0);
                    end else begin
                        check_eq("araddr", 64'(araddr), 64'(exp_ar_addr.pop_front()));
                        check_eq("arlen", 64'(arlen), 64'(exp_ar_len.pop_front()));
                    end
                    sb_addr.push_back(araddr);
                    sb_len.push_back(arlen);
                    sb_avail.push_back(cyc + r_delay);
                    pending++;
                    check_eq("outstd_le_max", 64'(pending > MAXO), 64'd0);
                end
                if (rd_done) begin
                    done_flag = 1;
                    ref_cyc = (exp_len == 0) ? accept_cyc : last_beat_cyc;
                    check_eq("done_latency", 64'(cyc - ref_cyc), 64'd1);
                    check_eq("rd_err", 64'(rd_err), 64'(exp_err));
                    check_eq("beats_left", 64'(exp_data.size()), 64'd0);
                    check_eq("ars_left", 64'(exp_ar_addr.size()), 64'd0);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; init_end = 1'b0; rd_trig = 1'b0; rd_addr = '0; rd_len = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_eq("rst_arvalid", 64'(arvalid), 64'd0);
        check_eq("rst_araddr", 64'(araddr), 64'd0);
        check_eq("rst_arlen", 64'(arlen), 64'd0);
        check_eq("rst_done", 64'(rd_done), 64'd0);
        check_eq("arid", 64'(arid), 64'hF);
        check_eq("arsize", 64'(arsize), 64'd1);
        check_eq("arburst", 64'(arburst), 64'd1);
        check_eq("ready_no_init", 64'(rd_ready), 64'd0);
        init_end = 1'b1;
        #1 check_eq("ready_init", 64'(rd_ready), 64'd1);

        // T1 single burst
        start_req(27'h000, 8);
        wait_done(200);
        // T2 multi-burst with random arready
        ar_rand = 1;
        start_req(27'h000, 40);
        wait_done(500);
        ar_rand = 0;
        // T3 row crossing
        start_req(27'h7FC, 6);
        wait_done(200);
        // T4 slow slave, plus a trigger while busy that must be ignored
        r_delay = 20;
        start_req(27'h100, 48);
        repeat (3) @(posedge clk);
        #1 rd_trig = 1'b1; rd_len = 16'd5;
        @(posedge clk); #1 rd_trig = 1'b0;
        wait_done(1000);
        r_delay = 0;
        // T5 user backpressure toggling
        toggle_mode = 1;
        start_req(27'h040, 16);
        wait_done(400);
        toggle_mode = 0;
        rd_data_ready = 1'b1;
        // T6 error response, empty request
        exp_err = 1; err_beat = 2;
        start_req(27'h200, 8);
        wait_done(200);
        exp_err = 0; err_beat = -1;
        start_req(27'h300, 0);
        wait_done(20);

        // Asynchronous reset mid-burst
        start_req(27'h000, 40);
        repeat (6) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_eq("arst_arvalid", 64'(arvalid), 64'd0);
        check_eq("arst_rready", 64'(rready), 64'd0);
        check_eq("arst_en", 64'(rd_data_en), 64'd0);
        check_eq("arst_done", 64'(rd_done), 64'd0);
        check_eq("arst_araddr", 64'(araddr), 64'd0);
        check_eq("arst_arlen", 64'(arlen), 64'd0);
        exp_ar_addr.delete(); exp_ar_len.delete(); exp_data.delete();
        sb_addr.delete(); sb_len.delete(); sb_avail.delete();
        slv_idx = 0; pending = 0;
        @(posedge clk); #1 rst = 1'b0;
        start_req(27'h020, 8);
        wait_done(200);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
